// File: rtl/adc_scan_scheduler_if.sv
// Signal bundle between the ADC scan scheduler, its request/result clients and the MCP3008 pins.
interface adc_scan_scheduler_if;
    logic       scan_en;
    logic       req_valid;
    logic [2:0] req_ch;
    logic       req_ready;
    logic       sclk;
    logic       cs_n;
    logic       din;
    logic       dout;
    logic       res_valid;
    logic [2:0] res_ch;
    logic [9:0] res_data;
    logic       res_is_req;
    logic       busy;

    modport master (
        output scan_en, req_valid, req_ch, dout,
        input  req_ready, sclk, cs_n, din, res_valid, res_ch, res_data, res_is_req, busy
    );

    modport slave (
        input  scan_en, req_valid, req_ch, dout,
        output req_ready, sclk, cs_n, din, res_valid, res_ch, res_data, res_is_req, busy
    );
endinterface

// File: rtl/adc_scan_scheduler.sv
// Time-shares one MCP3008 between a round-robin channel scan and one-shot requests,
// generating the SPI mode-0 frame and returning one tagged 10-bit result per conversion.
module adc_scan_scheduler #(
    parameter int unsigned CLK_DIV     = 27,
    parameter logic [7:0]  CH_MASK     = 8'hFF,
    parameter int unsigned GAP_PERIODS = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    adc_scan_scheduler_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StDone, StGap} state_e;

    localparam logic [7:0] DivLast       = 8'(CLK_DIV - 1);
    localparam logic [5:0] LastShiftHalf = 6'd33;
    localparam logic [5:0] FirstDataHalf = 6'd15;
    localparam logic [5:0] LastGapHalf   = 6'(2 * GAP_PERIODS - 1);

    state_e     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [5:0] half_q, half_d;
    logic [2:0] ptr_q, ptr_d;
    logic       slot_full_q, slot_full_d;
    logic [2:0] slot_ch_q, slot_ch_d;
    logic [2:0] cur_ch_q, cur_ch_d;
    logic       cur_is_req_q, cur_is_req_d;
    logic [9:0] shreg_q, shreg_d;
    logic       sclk_q, sclk_d;
    logic       cs_n_q, cs_n_d;
    logic       din_q, din_d;
    logic       res_valid_q, res_valid_d;
    logic [2:0] res_ch_q, res_ch_d;
    logic [9:0] res_data_q, res_data_d;
    logic       res_is_req_q, res_is_req_d;

    logic       scan_found;
    logic [2:0] scan_ch;
    logic [2:0] cand;
    logic       accept;
    logic       start_req;
    logic       half_end;
    logic       in_frame_d;

    // Lowest enabled channel at or above the pointer, wrapping past 7.
    always_comb begin
        scan_found = 1'b0;
        scan_ch    = 3'd0;
        cand       = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!scan_found && CH_MASK[cand]) begin
                scan_found = 1'b1;
                scan_ch    = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        half_d       = half_q;
        ptr_d        = ptr_q;
        cur_ch_d     = cur_ch_q;
        cur_is_req_d = cur_is_req_q;
        shreg_d      = shreg_q;
        res_ch_d     = res_ch_q;
        res_data_d   = res_data_q;
        res_is_req_d = res_is_req_q;
        start_req    = 1'b0;
        half_end     = (div_q == DivLast);
        accept       = bus.req_valid && !slot_full_q;

        unique case (state_q)
            StIdle: begin
                div_d  = '0;
                half_d = '0;
                if (slot_full_q) begin
                    start_req    = 1'b1;
                    cur_ch_d     = slot_ch_q;
                    cur_is_req_d = 1'b1;
                    state_d      = StSetup;
                end else if (bus.scan_en && scan_found) begin
                    cur_ch_d     = scan_ch;
                    cur_is_req_d = 1'b0;
                    state_d      = StSetup;
                end
            end
            StSetup, StShift: begin
                div_d = half_end ? '0 : div_q + 8'd1;
                if (half_end) begin
                    if (half_q == LastShiftHalf) begin
                        state_d = StDone;
                        half_d  = '0;
                    end else begin
                        state_d = StShift;
                        half_d  = half_q + 6'd1;
                    end
                end
                // First cycle of sclk high on edges 8..17 carries B9..B0.
                if (state_q == StShift && half_q[0] && div_q == '0 && half_q >= FirstDataHalf) begin
                    shreg_d = {shreg_q[8:0], bus.dout};
                end
            end
            StDone: begin
                state_d = StGap;
                div_d   = '0;
                half_d  = '0;
                if (!cur_is_req_q) begin
                    ptr_d = cur_ch_q + 3'd1;
                end
            end
            StGap: begin
                div_d = half_end ? '0 : div_q + 8'd1;
                if (half_end) begin
                    if (half_q == LastGapHalf) begin
                        state_d = StIdle;
                        half_d  = '0;
                    end else begin
                        half_d = half_q + 6'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A request accepted while a frame is being launched waits for the next one.
        slot_full_d = accept ? 1'b1 : (start_req ? 1'b0 : slot_full_q);
        slot_ch_d   = accept ? bus.req_ch : slot_ch_q;

        res_valid_d = (state_d == StDone);
        if (state_d == StDone) begin
            res_ch_d     = cur_ch_q;
            res_data_d   = shreg_d;
            res_is_req_d = cur_is_req_q;
        end

        in_frame_d = (state_d == StSetup) || (state_d == StShift);
        cs_n_d     = !in_frame_d;
        sclk_d     = (state_d == StShift) && half_d[0];
        din_d      = 1'b0;
        if (in_frame_d) begin
            // Bit for rising edge k is held over halves 2k-2 and 2k-1.
            case (half_d[5:1])
                5'd0, 5'd1: din_d = 1'b1;
                5'd2:       din_d = cur_ch_d[2];
                5'd3:       din_d = cur_ch_d[1];
                5'd4:       din_d = cur_ch_d[0];
                default:    din_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            div_q        <= '0;
            half_q       <= '0;
            ptr_q        <= '0;
            slot_full_q  <= 1'b0;
            slot_ch_q    <= '0;
            cur_ch_q     <= '0;
            cur_is_req_q <= 1'b0;
            shreg_q      <= '0;
            sclk_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            din_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            res_ch_q     <= '0;
            res_data_q   <= '0;
            res_is_req_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            half_q       <= half_d;
            ptr_q        <= ptr_d;
            slot_full_q  <= slot_full_d;
            slot_ch_q    <= slot_ch_d;
            cur_ch_q     <= cur_ch_d;
            cur_is_req_q <= cur_is_req_d;
            shreg_q      <= shreg_d;
            sclk_q       <= sclk_d;
            cs_n_q       <= cs_n_d;
            din_q        <= din_d;
            res_valid_q  <= res_valid_d;
            res_ch_q     <= res_ch_d;
            res_data_q   <= res_data_d;
            res_is_req_q <= res_is_req_d;
        end
    end

    assign bus.req_ready  = !slot_full_q;
    assign bus.sclk       = sclk_q;
    assign bus.cs_n       = cs_n_q;
    assign bus.din        = din_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_ch     = res_ch_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_is_req = res_is_req_q;
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Bench for adc_scan_scheduler: MCP3008 behavioural model, full-mask and sparse-mask instances.
module tb_adc_scan_scheduler;
    localparam int unsigned ClkDiv     = 2;
    localparam int unsigned GapPeriods = 1;
    localparam int          FrameLow   = 34 * ClkDiv;

    typedef struct packed {
        logic [2:0] ch;
        logic [9:0] data;
        logic       is_req;
    } res_t;

    typedef struct packed {
        logic [2:0] ch;
        logic       ovr;
        logic [9:0] val;
        logic [9:0] exp_data;
        logic [4:0] exp_cmd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    adc_scan_scheduler_if bus0 ();
    adc_scan_scheduler_if bus1 ();

    adc_scan_scheduler #(.CLK_DIV(ClkDiv), .CH_MASK(8'hFF), .GAP_PERIODS(GapPeriods)) u_dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    adc_scan_scheduler #(.CLK_DIV(ClkDiv), .CH_MASK(8'b1010_0100), .GAP_PERIODS(GapPeriods)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ADC model 0: decodes the command from din, returns 0x200+ch unless overridden.
    int         edge0 = 0;
    logic [4:0] cmd0 = '0;
    logic [9:0] val0 = '0;
    logic       use_ovr = 1'b0;
    logic [9:0] ovr_val = '0;

    always @(posedge bus0.sclk or negedge bus0.cs_n) begin
        if (!bus0.sclk) begin
            edge0 = 0;
            cmd0  = '0;
        end else begin
            edge0++;
            if (edge0 <= 5) cmd0 = {cmd0[3:0], bus0.din};
        end
    end

    always @(negedge bus0.sclk or negedge bus0.cs_n) begin
        val0 = use_ovr ? ovr_val : 10'h200 + 10'(cmd0[2:0]);
        bus0.dout = (edge0 >= 7 && edge0 <= 16) ? val0[4'(16 - edge0)] : 1'b0;
    end

    int edge1 = 0;
    logic [4:0] cmd1 = '0;
    logic [9:0] val1 = '0;

    always @(posedge bus1.sclk or negedge bus1.cs_n) begin
        if (!bus1.sclk) begin
            edge1 = 0;
            cmd1  = '0;
        end else begin
            edge1++;
            if (edge1 <= 5) cmd1 = {cmd1[3:0], bus1.din};
        end
    end

    always @(negedge bus1.sclk or negedge bus1.cs_n) begin
        val1 = 10'h200 + 10'(cmd1[2:0]);
        bus1.dout = (edge1 >= 7 && edge1 <= 16) ? val1[4'(16 - edge1)] : 1'b0;
    end

    // Result capture and pin-level monitors, sampled on the falling clk edge.
    res_t q0[$];
    res_t q1[$];
    int low0 = 0, last_low0 = 0, high0 = 0, last_high0 = 0;
    int viol0 = 0, setup_viol0 = 0, frames0 = 0;

    always @(negedge clk) begin
        if (!bus0.cs_n) begin
            if (low0 == 0) begin
                frames0++;
                last_high0 = high0;
            end
            if (low0 < ClkDiv && bus0.sclk) setup_viol0++;
            low0++;
            high0 = 0;
        end else begin
            if (low0 != 0) last_low0 = low0;
            low0 = 0;
            high0++;
            if (bus0.sclk || bus0.din) viol0++;
        end
        if (bus0.res_valid) q0.push_back('{bus0.res_ch, bus0.res_data, bus0.res_is_req});
        if (bus1.res_valid) q1.push_back('{bus1.res_ch, bus1.res_data, bus1.res_is_req});
    end

    vec_t vecs[5];

    initial begin
        int base;
        int frames_start;
        int bad;
        vecs[0] = '{3'd0, 1'b1, 10'h3FF, 10'h3FF, 5'b11000};
        vecs[1] = '{3'd5, 1'b1, 10'h155, 10'h155, 5'b11101};
        vecs[2] = '{3'd7, 1'b1, 10'h2AA, 10'h2AA, 5'b11111};
        vecs[3] = '{3'd3, 1'b0, 10'h000, 10'h203, 5'b11011};
        vecs[4] = '{3'd6, 1'b1, 10'h001, 10'h001, 5'b11110};

        bus0.scan_en = 1'b0; bus0.req_valid = 1'b0; bus0.req_ch = 3'd0;
        bus1.scan_en = 1'b0; bus1.req_valid = 1'b0; bus1.req_ch = 3'd0;
        repeat (3) @(negedge clk);

        check("rst_cs_n", bus0.cs_n, 1);
        check("rst_sclk", bus0.sclk, 0);
        check("rst_din", bus0.din, 0);
        check("rst_res_valid", bus0.res_valid, 0);
        check("rst_res_ch", bus0.res_ch, 0);
        check("rst_res_data", bus0.res_data, 0);
        check("rst_res_is_req", bus0.res_is_req, 0);
        check("rst_busy", bus0.busy, 0);
        check("rst_req_ready", bus0.req_ready, 1);

        // Free-running scan on both instances.
        bus0.scan_en = 1'b1;
        bus1.scan_en = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 2000 && (q0.size() < 9 || q1.size() < 4); i++) @(negedge clk);
        check("scan_count0", q0.size() >= 9, 1);
        check("scan_count1", q1.size() >= 4, 1);
        if (q0.size() >= 9) begin
            for (int k = 0; k < 9; k++) begin
                check("scan_ch", q0[k].ch, k % 8);
                check("scan_data", q0[k].data, 10'h200 + 10'(k % 8));
                check("scan_is_req", q0[k].is_req, 0);
            end
        end
        if (q1.size() >= 4) begin
            check("mask_ch0", q1[0].ch, 2);
            check("mask_ch1", q1[1].ch, 5);
            check("mask_ch2", q1[2].ch, 7);
            check("mask_ch3", q1[3].ch, 2);
            check("mask_data", q1[1].data, 10'h205);
        end
        check("frame_low_len", last_low0, FrameLow);
        check("gap_len_min", last_high0 >= 2 * ClkDiv * GapPeriods, 1);

        // Request during the ch 3 scan frame.
        for (int i = 0; i < 1500 && !(!bus0.cs_n && edge0 == 6 && cmd0[2:0] == 3'd3); i++)
            @(negedge clk);
        check("found_ch3_frame", !bus0.cs_n && edge0 == 6 && cmd0[2:0] == 3'd3, 1);
        base = q0.size();
        bus0.req_ch = 3'd6;
        bus0.req_valid = 1'b1;
        @(negedge clk);
        check("req_ready_low", bus0.req_ready, 0);
        bus0.req_valid = 1'b0;
        for (int i = 0; i < 600 && q0.size() < base + 3; i++) @(negedge clk);
        check("req_seq_count", q0.size() >= base + 3, 1);
        if (q0.size() >= base + 3) begin
            check("req_seq0", q0[base], {3'd3, 10'h203, 1'b0});
            check("req_seq1", q0[base + 1], {3'd6, 10'h206, 1'b1});
            check("req_seq2", q0[base + 2], {3'd4, 10'h204, 1'b0});
        end
        check("req_ready_back", bus0.req_ready, 1);

        // Scan disabled: the bus must stay quiet.
        bus0.scan_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 300 && bus0.busy; i++) @(negedge clk);
        check("idle_busy", bus0.busy, 0);
        base = q0.size();
        frames_start = frames0;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (!bus0.cs_n || bus0.busy) bad++;
        end
        check("idle_quiet", bad, 0);
        check("idle_no_result", q0.size(), base);
        check("idle_no_frame", frames0, frames_start);

        // One-shot request vectors.
        foreach (vecs[v]) begin
            use_ovr = vecs[v].ovr;
            ovr_val = vecs[v].val;
            base = q0.size();
            bus0.req_ch = vecs[v].ch;
            bus0.req_valid = 1'b1;
            @(negedge clk);
            bus0.req_valid = 1'b0;
            for (int i = 0; i < 300 && q0.size() <= base; i++) @(negedge clk);
            check("vec_result", q0.size() > base, 1);
            if (q0.size() > base) begin
                check("vec_ch", q0[base].ch, vecs[v].ch);
                check("vec_data", q0[base].data, vecs[v].exp_data);
                check("vec_is_req", q0[base].is_req, 1);
            end
            check("vec_din_cmd", cmd0, vecs[v].exp_cmd);
            check("vec_low_len", last_low0, FrameLow);
        end
        check("pins_idle_quiet", viol0, 0);
        check("setup_sclk_low", setup_viol0, 0);

        // Asynchronous reset in the middle of a scan frame.
        use_ovr = 1'b0;
        bus0.scan_en = 1'b1;
        for (int i = 0; i < 600 && !(!bus0.cs_n && edge0 == 10); i++) @(negedge clk);
        check("found_edge10", !bus0.cs_n && edge0 == 10, 1);
        base = q0.size();
        rst_n = 1'b0;
        #1;
        check("arst_cs_n", bus0.cs_n, 1);
        check("arst_sclk", bus0.sclk, 0);
        check("arst_req_ready", bus0.req_ready, 1);
        check("arst_res_valid", bus0.res_valid, 0);
        check("arst_busy", bus0.busy, 0);
        repeat (3) @(negedge clk);
        check("arst_no_result", q0.size(), base);
        rst_n = 1'b1;
        for (int i = 0; i < 300 && q0.size() <= base; i++) @(negedge clk);
        check("post_rst_result", q0.size() > base, 1);
        if (q0.size() > base) begin
            check("post_rst_ch", q0[base].ch, 0);
            check("post_rst_data", q0[base].data, 10'h200);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
